// File: rtl/trace_capture_unit_if.sv
// trace_capture_unit_if: probe, trigger, readback and status signals of the trace buffer.
interface trace_capture_unit_if #(
   parameter int WIDTH = 32,
   parameter int CHANNELS = 4,
   parameter int DEPTH = 16
);
   localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   localparam int AW = $clog2(DEPTH);
   logic                      arm;
   logic                      probe_valid;
   logic [CHANNELS*WIDTH-1:0] probe_in;
   logic [CW-1:0]             trig_ch;
   logic [WIDTH-1:0]          trig_value;
   logic [AW-1:0]             rd_addr;
   logic [CW-1:0]             rd_ch;
   logic [WIDTH-1:0]          rd_data;
   logic [31:0]               rd_ts;
   logic                      armed;
   logic                      triggered;
   logic                      done;
   logic [AW:0]               count;
   modport master (output arm, probe_valid, probe_in, trig_ch, trig_value, rd_addr, rd_ch,
                   input rd_data, rd_ts, armed, triggered, done, count);
   modport slave (input arm, probe_valid, probe_in, trig_ch, trig_value, rd_addr, rd_ch,
                  output rd_data, rd_ts, armed, triggered, done, count);
endinterface

// File: rtl/trace_capture_unit.sv
// trace_capture_unit: DEPTH-entry ring trace buffer that freezes POST_TRIG samples after a value match.
// Optional TRACE_TIMESTAMP_EN stores a free-running 32-bit cycle stamp with every sample.
module trace_capture_unit #(
   parameter int WIDTH = 32,
   parameter int CHANNELS = 4,
   parameter int DEPTH = 16,
   parameter int POST_TRIG = 8
) (
   input logic clk,
   input logic rst_n,
   trace_capture_unit_if.slave bus
);
   localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
   state_t state, state_nxt;
   logic [AW-1:0] wr_ptr, phys;
   logic [AW:0] count, post_cnt;
   logic [CW-1:0] trig_sel, rd_sel;
   logic hit, cap;
   logic [CHANNELS*WIDTH-1:0] mem [DEPTH];
   always_comb begin
      trig_sel = int'(bus.trig_ch) < CHANNELS ? bus.trig_ch : '0;
      rd_sel = int'(bus.rd_ch) < CHANNELS ? bus.rd_ch : '0;
      cap = (state == ARMED || state == POST) && bus.probe_valid && !bus.arm;
      hit = state == ARMED && bus.probe_valid && bus.probe_in[int'(trig_sel)*WIDTH +: WIDTH] == bus.trig_value;
      phys = count == FULL ? wr_ptr + bus.rd_addr : bus.rd_addr;
      state_nxt = state;
      if (bus.arm) state_nxt = ARMED;
      else if (hit) state_nxt = POST_TRIG == 0 ? DONE : POST;
      else if (cap && state == POST && post_cnt == (AW + 1)'(1)) state_nxt = DONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         wr_ptr <= '0;
         count <= '0;
         post_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (bus.arm) begin
            wr_ptr <= '0;
            count <= '0;
            post_cnt <= (AW + 1)'(POST_TRIG);
         end else if (cap) begin
            wr_ptr <= wr_ptr + 1'b1;
            count <= count == FULL ? count : count + 1'b1;
            if (state == POST) post_cnt <= post_cnt - 1'b1;
         end
      end
   end
   // Sample storage carries no reset so it survives an aborted capture.
   always_ff @(posedge clk) if (cap) mem[wr_ptr] <= bus.probe_in;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.rd_data <= '0;
      else bus.rd_data <= mem[phys][int'(rd_sel)*WIDTH +: WIDTH];
   end
`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] ts;
   logic [31:0] ts_mem [DEPTH];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts <= '0;
         bus.rd_ts <= '0;
      end else begin
         ts <= ts + 1'b1;
         bus.rd_ts <= ts_mem[phys];
      end
   end
   always_ff @(posedge clk) if (cap) ts_mem[wr_ptr] <= ts;
`else
   assign bus.rd_ts = '0;
`endif
   assign bus.armed = state == ARMED;
   assign bus.triggered = state == POST || state == DONE;
   assign bus.done = state == DONE;
   assign bus.count = count;
endmodule

// File: tb/tb_trace_capture_unit.sv
// tb_trace_capture_unit: directed vector table plus hand sequences for wrap, POST_TRIG=0, arm priority and async reset.
module tb_trace_capture_unit;
   logic clk = 0;
   logic rst_n = 0;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   trace_capture_unit_if #(.WIDTH(32), .CHANNELS(4), .DEPTH(16)) b0 ();
   trace_capture_unit_if #(.WIDTH(32), .CHANNELS(4), .DEPTH(16)) b1 ();
   trace_capture_unit #(.WIDTH(32), .CHANNELS(4), .DEPTH(16), .POST_TRIG(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   trace_capture_unit #(.WIDTH(32), .CHANNELS(4), .DEPTH(16), .POST_TRIG(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
   typedef struct {
      logic arm;
      logic v;
      logic [31:0] ch0;
      logic [7:0] st;
   } vec_t;
   vec_t vecs [19];
   logic [31:0] exp_main [11] = '{1, 2, 3, 4, 3, 6, 7, 8, 9, 10, 11};
   logic [31:0] q [$];
   logic [31:0] ts_rd [16];
   function automatic vec_t mk(input int a, input int v, input int c, input int ar, input int tr, input int dn, input int cnt);
      vec_t r;
      r.arm = a[0];
      r.v = v[0];
      r.ch0 = c;
      r.st = {ar[0], tr[0], dn[0], cnt[4:0]};
      return r;
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   function automatic logic [7:0] st0;
      return {b0.armed, b0.triggered, b0.done, b0.count};
   endfunction
   task automatic apply(input int i);
      b0.arm = vecs[i].arm;
      b0.probe_valid = vecs[i].v;
      b0.probe_in = {64'd0, vecs[i].ch0 + 32'd1000, vecs[i].ch0};
      step();
      chk($sformatf("row%0d", i), 64'(st0()), 64'(vecs[i].st));
   endtask
   initial begin
      vecs[0] = mk(1, 0, 0, 1, 0, 0, 0);
      vecs[1] = mk(0, 1, 1, 1, 0, 0, 1);
      vecs[2] = mk(0, 0, 9, 1, 0, 0, 1);
      vecs[3] = mk(0, 1, 2, 1, 0, 0, 2);
      vecs[4] = mk(0, 1, 3, 0, 1, 0, 3);
      vecs[5] = mk(0, 1, 4, 0, 1, 0, 4);
      vecs[6] = mk(0, 1, 3, 0, 1, 0, 5);
      vecs[7] = mk(0, 1, 6, 0, 1, 0, 6);
      vecs[8] = mk(0, 0, 7, 0, 1, 0, 6);
      vecs[9] = mk(0, 1, 7, 0, 1, 0, 7);
      vecs[10] = mk(0, 1, 8, 0, 1, 0, 8);
      vecs[11] = mk(0, 1, 9, 0, 1, 0, 9);
      vecs[12] = mk(0, 1, 10, 0, 1, 0, 10);
      vecs[13] = mk(0, 1, 11, 0, 1, 1, 11);
      vecs[14] = mk(0, 1, 12, 0, 1, 1, 11);
      vecs[15] = mk(1, 1, 3, 1, 0, 0, 0);
      vecs[16] = mk(0, 1, 3, 0, 1, 0, 1);
      vecs[17] = mk(0, 1, 5, 0, 1, 0, 2);
      vecs[18] = mk(1, 0, 0, 1, 0, 0, 0);
      {b0.arm, b0.probe_valid, b0.probe_in, b0.trig_ch, b0.rd_addr, b0.rd_ch} = '0;
      {b1.arm, b1.probe_valid, b1.probe_in, b1.trig_ch, b1.rd_addr, b1.rd_ch} = '0;
      b0.trig_value = 3;
      b1.trig_value = 42;
      #1;
      chk("reset_state", 64'(st0()), 64'd0);
      chk("reset_rd_data", 64'(b0.rd_data), 64'd0);
      chk("reset_rd_ts", 64'(b0.rd_ts), 64'd0);
      step();
      rst_n = 1;
      b0.probe_valid = 1;
      b0.probe_in = {96'd0, 32'd3};
      repeat (5) step();
      chk("idle_no_capture", 64'(st0()), 64'd0);
      for (int i = 0; i < 15; i++) apply(i);
      b0.probe_valid = 0;
      for (int i = 0; i < 11; i++) begin
         b0.rd_addr = 4'(i);
         step();
         chk($sformatf("main_rd%0d", i), 64'(b0.rd_data), 64'(exp_main[i]));
         ts_rd[i] = b0.rd_ts;
      end
      b0.rd_addr = 2;
      b0.rd_ch = 1;
      step();
      chk("main_rd_ch1", 64'(b0.rd_data), 64'd1003);
`ifdef TRACE_TIMESTAMP_EN
      chk("main_ts_gap", 64'(ts_rd[1] - ts_rd[0]), 64'd2);
      chk("main_ts_next", 64'(ts_rd[2] - ts_rd[1]), 64'd1);
`else
      chk("main_ts_zero", 64'(ts_rd[1] | ts_rd[0]), 64'd0);
`endif
      for (int i = 15; i < 19; i++) apply(i);
      b0.arm = 0;
      b0.trig_ch = 1;
      b0.trig_value = 999;
      for (int i = 0; i < 29; i++) begin
         logic [31:0] val;
         val = i < 20 ? 32'(100 + i) : i == 20 ? 32'd999 : 32'(200 + i - 21);
         q.push_back(val);
         b0.probe_valid = 1;
         b0.probe_in = {64'd0, val, 32'd0};
         step();
         if (i == 19) chk("wrap_pre_trig", 64'(st0()), 64'({3'b100, 5'd16}));
         if (i == 20) chk("wrap_trig", 64'(st0()), 64'({3'b010, 5'd16}));
      end
      chk("wrap_done", 64'(st0()), 64'({3'b011, 5'd16}));
      b0.probe_valid = 0;
      b0.rd_ch = 1;
      for (int i = 0; i < 16; i++) begin
         b0.rd_addr = 4'(i);
         step();
         chk($sformatf("wrap_rd%0d", i), 64'(b0.rd_data), 64'(q[q.size() - 16 + i]));
         ts_rd[i] = b0.rd_ts;
      end
`ifdef TRACE_TIMESTAMP_EN
      chk("wrap_ts_span", 64'(ts_rd[15] - ts_rd[0]), 64'd15);
`else
      chk("wrap_ts_zero", 64'(ts_rd[15]), 64'd0);
`endif
      b1.arm = 1;
      step();
      b1.arm = 0;
      b1.probe_valid = 1;
      b1.probe_in = {96'd0, 32'd42};
      step();
      b1.probe_valid = 0;
      chk("pt0_done", 64'({b1.armed, b1.triggered, b1.done, b1.count}), 64'({3'b011, 5'd1}));
      step();
      chk("pt0_rd", 64'(b1.rd_data), 64'd42);
      b0.trig_ch = 0;
      b0.trig_value = 3;
      b0.rd_ch = 0;
      b0.rd_addr = 0;
      b0.arm = 1;
      step();
      b0.arm = 0;
      b0.probe_valid = 1;
      b0.probe_in = {96'd0, 32'd3};
      step();
      b0.probe_in = {96'd0, 32'd77};
      step();
      b0.probe_valid = 0;
      chk("rst_pre_post", 64'(st0()), 64'({3'b010, 5'd2}));
      rst_n = 0;
      #1;
      chk("rst_async", 64'(st0()), 64'd0);
      step();
      rst_n = 1;
      step();
      chk("rst_mem_kept", 64'(b0.rd_data), 64'd3);
      chk("rst_idle", 64'(st0()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/trace_capture_unit.md
Name: trace_capture_unit

Overview:
- Parametrised on-chip trace buffer for processor debug. Samples CHANNELS probe words of WIDTH bits (e.g. instr, reg_check, data_mem_check, Rc) into a DEPTH-entry ring.
- Freezes capture a programmable number of samples after a value-match trigger; contents are read back afterwards.
- Sits beside the pipelined processor, replacing free-running waveform probing with a synthesizable, post-trigger-windowed capture.

Parameters:
WIDTH, 32, bits per probe channel
CHANNELS, 4, number of probe channels captured per sample
DEPTH, 16, ring entries; power of two, >= 2
POST_TRIG, 8, samples captured after the trigger sample; 0 <= POST_TRIG <= DEPTH-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
arm  in  1  single-cycle pulse; clears pointers and starts capture
probe_valid  in  1  probe_in holds a sample this cycle
probe_in  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
trig_ch  in  clog2(CHANNELS) (min 1)  channel compared for trigger
trig_value  in  WIDTH  trigger compare value
rd_addr  in  clog2(DEPTH)  logical read index, 0 = oldest stored sample
rd_ch  in  clog2(CHANNELS) (min 1)  channel to read
rd_data  out  WIDTH  registered readback word
rd_ts  out  32  registered timestamp readback (see Optional Feature)
armed  out  1  state is ARMED
triggered  out  1  state is POST or DONE
done  out  1  state is DONE
count  out  clog2(DEPTH)+1  stored samples, saturates at DEPTH

Behaviour:
- Reset (async, rst_n=0): state IDLE; wr_ptr=0, post_cnt=0, count=0, rd_data=0, rd_ts=0, all flags 0. Memory contents are not reset.
- States: IDLE, ARMED, POST, DONE.
- arm=1 in any state: next state ARMED; wr_ptr=0, count=0, post_cnt=POST_TRIG. A probe_valid in the same cycle is not written. arm has priority over every other event.
- Capture rule: in ARMED or POST, each probe_valid cycle writes all channels to mem[wr_ptr]. wr_ptr increments mod DEPTH (wraps DEPTH-1 -> 0) and count increments, saturating at DEPTH. No writes in IDLE or DONE.
- Trigger: in ARMED, probe_valid=1 with probe_in channel trig_ch == trig_value. The trigger sample itself is written.
  - POST_TRIG=0: go to DONE.
  - POST_TRIG>0: go to POST.
- POST: each probe_valid write decrements post_cnt. The write that takes post_cnt from 1 to 0 moves the state to DONE. Trigger matches in POST are ignored.
- probe_valid=0 cycles do not advance any counter or state.
- Readback is combinational address, registered data, 1-cycle latency in all states:
  - rd_data = channel rd_ch of mem[phys].
  - phys = (count==DEPTH) ? (wr_ptr+rd_addr) mod DEPTH : rd_addr.
  - rd_addr >= count returns stale memory; the bench must not check it.
- trig_ch >= CHANNELS compares against channel 0. rd_ch >= CHANNELS reads channel 0.
- Reset mid-capture aborts to IDLE. Already-written memory may be read back, but count=0.

Optional Feature:
TRACE_TIMESTAMP_EN
- Defined:
  - A 32-bit free-running cycle counter, reset to 0, wrapping at 2^32-1 -> 0, is stored with each sample.
  - rd_ts returns the stored timestamp of the addressed entry with the same 1-cycle latency as rd_data.
- Undefined: no counter or timestamp storage; rd_ts is held at 0.

Test Plan:
- Reset then idle: probe_valid=1 for 5 cycles without arm -> count=0, armed=0, done=0, rd_data=0.
- Defaults, arm, then 4 samples with ch0 = 1,2,3,4 and trig_value=3 on trig_ch=0:
  - Expected: triggered after sample 3, count=4.
  - Feed 7 more valid samples -> done after the 8th post sample (total 11), count=11.
  - Further probe_valid: no change.
- Wrap: arm with trig_value unmatched, push 20 samples with ch1 = 100..119, then match:
  - Expected: count=16.
  - After done, rd_addr=0 rd_ch=1 returns the oldest retained value (trigger+8-15 ordering); consecutive rd_addr values return increasing values.
- POST_TRIG=0 instance: trigger on the first sample -> done next cycle, count=1, rd_addr=0 returns the trigger word.
- Simultaneous events: arm asserted with a matching probe_valid sample -> state ARMED, count=0, no trigger. Then arm pulsed during POST -> restart in ARMED with count=0.
- Reset mid-POST: rst_n low for one cycle -> all flags 0, count=0 immediately (asynchronous, before the next clk edge). With TRACE_TIMESTAMP_EN, timestamps of consecutive valid samples differ by the number of elapsed cycles.
